alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Self-checking response monitor for the 32-bit ALU (A, B, F → Y, OF). It accepts one vector per handshake: the operands, the function code, and the ALU's actual Y/OF. It recomputes the golden result, compares it, and keeps pass/error statistics for a run terminated by a last-flagged vector. The stimulus generator drives vectors into the ALU; this block sits at the result end of that path, alongside the ALU in FPGA self-test builds.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥ 2)
- CNT_W, 16, width of vector/error counters and error index

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE and DONE only)
- in_valid  in  1  vector beat valid
- in_ready  out  1  checker can accept a beat
- in_last  in  1  qualifies the beat as the final vector of the run
- a, b  in  WIDTH  operands applied to the ALU
- f  in  3  ALU function code applied
- y  in  WIDTH  ALU result observed
- of  in  1  ALU overflow observed
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  high in DONE when err_count == 0
- mismatch  out  1  one-cycle pulse per failing vector
- vec_count  out  CNT_W  vectors checked in the current run
- err_count  out  CNT_W  failing vectors in the current run
- first_err_idx  out  CNT_W  index (0-based) of the first failing vector
- first_err_f  out  3  f of the first failing vector
- first_err_y  out  WIDTH  expected Y of the first failing vector

## Operation
- Golden model, with msb = WIDTH-1:
  - 000 AND: y = a&b, of = 0
  - 001 OR: y = a|b, of = 0
  - 010 ADD: y = a+b mod 2^WIDTH; of = (a[msb]==b[msb]) & (y[msb]!=a[msb])
  - 110 SUB: y = a−b mod 2^WIDTH; of = (a[msb]!=b[msb]) & (y[msb]!=a[msb])
  - 111 SLT: y = {0…0, diff[msb]^sub_of}, where diff and sub_of are the SUB result and SUB overflow; of = 0
  - 011/100/101: unsupported; the vector counts as an error, with expected y = 0.
- Mismatch condition: any y bit differs, or of differs, or f is unsupported.
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start. Entering RUN clears vec_count, err_count and the first-error record.
  - RUN→DRAIN on an accepted beat with in_last = 1.
  - DRAIN→DONE after exactly one cycle.
  - DONE→RUN on start.
  - start is ignored in RUN and DRAIN.
- in_ready = 1 only in RUN. A beat is accepted when in_valid & in_ready.
- Two-stage pipeline:
  - The accepted beat is registered into stage 1.
  - Stage 2 registers the compare result and updates the counters and the first-error record.
- vec_count and err_count saturate at 2^CNT_W−1; no wrap.
- The first-error record is written only while err_count == 0 before the increment.

## Timing
- Reset: state = IDLE. All outputs are 0, including in_ready, busy, done, pass, mismatch, all counters and the record. Stage-1 valid is cleared.
- Reset mid-run aborts immediately. No partial results persist.
- A beat accepted at edge k:
  - vec_count, err_count and the record update at edge k+1.
  - mismatch is high for the cycle following edge k+1.
- in_last accepted at edge k:
  - DRAIN during cycle k..k+1.
  - done = 1 from edge k+1; final counts are visible in the same cycle.
- A back-to-back beat every cycle is sustained in RUN, with no bubbles.
- In DONE, counts, pass and the record hold until start or reset.
- start and reset in the same cycle: reset wins.

## Configuration
- ALU_CHK_FIRST_ERR_EN defined: the first-error record (first_err_idx, first_err_f, first_err_y) is captured as above.
- Not defined: the record registers are not built, and those outputs are tied to 0. Counters, pass and mismatch are unchanged.

## Test plan
- ADD overflow: start; beat a=7FFFFFFF, b=7FFFFFFF, f=2, y=FFFFFFFE, of=1, last → mismatch never asserted; done with vec_count=1, err_count=0, pass=1.
- SUB/SLT mix: a=00000000, b=FFFFFFFF, f=6, y=00000001, of=0; then a=FFFFFFFF, b=00000001, f=7, y=00000001, of=0, last → err_count=0, vec_count=2.
- Injected faults: 3 vectors where vector index 1 is a=12345678, b=87654321, f=2 with y=99999998 (expected 99999999) and index 2 has a wrong of → err_count=2, pass=0, first_err_idx=1, first_err_f=2, first_err_y=99999999. With the macro undefined, the record reads 0.
- Unsupported f=3 with y=0, of=0 → counted as an error; mismatch pulses once.
- Saturation with CNT_W=4: 20 failing back-to-back beats → vec_count=err_count=F, no wrap. start during RUN has no effect.
- Reset after 5 accepted beats mid-run → all outputs 0 and state IDLE next cycle. A new start/run of 1 good vector gives vec_count=1, pass=1.

Source files
------------

// File: rtl/alu_result_checker.sv
// Result checker for a 32-bit ALU: recomputes Y/OF per vector, counts mismatches over a run.
// Optional first-error record is built only when ALU_CHK_FIRST_ERR_EN is defined.
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  input  logic [WIDTH-1:0] y,
  input  logic             of,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_f,
  output logic [WIDTH-1:0] first_err_y
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam int MSB = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_y_q, s1_y_d;
  logic [2:0]       s1_f_q, s1_f_d;
  logic             s1_of_q, s1_of_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d, err_count_q, err_count_d;

  logic             accept, start_run;
  logic [WIDTH-1:0] sum, diff, exp_y;
  logic             add_of, sub_of, exp_of, unsupported, bad;

  assign accept    = in_valid && (state_q == ST_RUN);
  assign start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_run) state_d = ST_RUN;
      ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  if (start_run) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stage 1 captures the beat; data lanes only load on accept.
  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_f_d     = s1_f_q;
    s1_y_d     = s1_y_q;
    s1_of_d    = s1_of_q;
    if (accept) begin
      s1_a_d  = a;
      s1_b_d  = b;
      s1_f_d  = f;
      s1_y_d  = y;
      s1_of_d = of;
    end
  end

  always_comb begin
    sum         = s1_a_q + s1_b_q;
    diff        = s1_a_q - s1_b_q;
    add_of      = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
    sub_of      = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
    exp_y       = '0;
    exp_of      = 1'b0;
    unsupported = 1'b0;
    case (s1_f_q)
      3'b000:  exp_y = s1_a_q & s1_b_q;
      3'b001:  exp_y = s1_a_q | s1_b_q;
      3'b010:  begin exp_y = sum;  exp_of = add_of; end
      3'b110:  begin exp_y = diff; exp_of = sub_of; end
      3'b111:  exp_y = {{(WIDTH-1){1'b0}}, diff[MSB] ^ sub_of};
      default: unsupported = 1'b1;
    endcase
    bad = s1_valid_q && (unsupported || (s1_y_q != exp_y) || (s1_of_q != exp_of));
  end

  always_comb begin
    mismatch_d  = bad;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    if (start_run) begin
      vec_count_d = '0;
      err_count_d = '0;
    end else if (s1_valid_q) begin
      if (vec_count_q != CNT_MAX) vec_count_d = vec_count_q + 1'b1;
      if (bad && (err_count_q != CNT_MAX)) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_f_q      <= '0;
      s1_y_q      <= '0;
      s1_of_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      vec_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_f_q      <= s1_f_d;
      s1_y_q      <= s1_y_d;
      s1_of_q     <= s1_of_d;
      mismatch_q  <= mismatch_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef ALU_CHK_FIRST_ERR_EN
  logic [CNT_W-1:0] rec_idx_q, rec_idx_d;
  logic [2:0]       rec_f_q, rec_f_d;
  logic [WIDTH-1:0] rec_y_q, rec_y_d;

  // Only the first failure of a run is kept: err_count is still zero when it arrives.
  always_comb begin
    rec_idx_d = rec_idx_q;
    rec_f_d   = rec_f_q;
    rec_y_d   = rec_y_q;
    if (start_run) begin
      rec_idx_d = '0;
      rec_f_d   = '0;
      rec_y_d   = '0;
    end else if (bad && (err_count_q == '0)) begin
      rec_idx_d = vec_count_q;
      rec_f_d   = s1_f_q;
      rec_y_d   = exp_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_idx_q <= '0;
      rec_f_q   <= '0;
      rec_y_q   <= '0;
    end else begin
      rec_idx_q <= rec_idx_d;
      rec_f_q   <= rec_f_d;
      rec_y_q   <= rec_y_d;
    end
  end

  assign first_err_idx = rec_idx_q;
  assign first_err_f   = rec_f_q;
  assign first_err_y   = rec_y_q;
`else
  assign first_err_idx = '0;
  assign first_err_f   = '0;
  assign first_err_y   = '0;
`endif

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_count_q == '0);
  assign mismatch  = mismatch_q;
  assign vec_count = vec_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: driver queues expected mismatch bits, monitor pops them.
module tb_alu_result_checker;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, in_last, of;
  logic [WIDTH-1:0] a, b, y;
  logic [2:0]       f;
  logic             in_ready, busy, done, pass, mismatch;
  logic [CNT_W-1:0] vec_count, err_count, first_err_idx;
  logic [2:0]       first_err_f;
  logic [WIDTH-1:0] first_err_y;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  mm_seen  = 0;
  bit  exp_q[$];
  bit  pend1 = 1'b0;
  bit  pend2 = 1'b0;

  alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a(a), .b(b), .f(f), .y(y), .of(of), .busy(busy), .done(done),
    .pass(pass), .mismatch(mismatch), .vec_count(vec_count), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_f(first_err_f), .first_err_y(first_err_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: mismatch for a beat accepted at edge k is visible in the cycle after edge k+1.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pend1 = 1'b0;
      pend2 = 1'b0;
    end else begin
      if (pend2) begin
        if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
        else check("mismatch_beat", mismatch, exp_q.pop_front());
      end
      pend2 = pend1;
      pend1 = in_valid && in_ready;
    end
    if (mismatch) mm_seen++;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] vf,
                            input logic [31:0] vy, input logic vof, input logic vlast, input bit exp_mm);
    int n = 0;
    a = va; b = vb; f = vf; y = vy; of = vof; in_last = vlast; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("beat_accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_mm);
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_vec_count"}, vec_count, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_err"}, {first_err_idx, first_err_f, first_err_y}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int mm0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    a = '0; b = '0; f = '0; y = '0; of = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD with signed overflow, correct result
    pulse_start();
    check("run_in_ready", in_ready, 1);
    check("run_busy", busy, 1);
    mm0 = mm_seen;
    drive_beat(32'h7FFFFFFF, 32'h7FFFFFFF, 3'd2, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0);
    idle_inputs();
    wait_done("add");
    check("add_vec_count", vec_count, 1);
    check("add_err_count", err_count, 0);
    check("add_pass", pass, 1);
    check("add_no_mismatch", mm_seen - mm0, 0);

    // SUB then SLT, started from DONE
    pulse_start();
    check("sub_restart_cleared", vec_count, 0);
    drive_beat(32'h00000000, 32'hFFFFFFFF, 3'd6, 32'h00000001, 1'b0, 1'b0, 1'b0);
    drive_beat(32'hFFFFFFFF, 32'h00000001, 3'd7, 32'h00000001, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    wait_done("subslt");
    check("subslt_vec_count", vec_count, 2);
    check("subslt_err_count", err_count, 0);
    check("subslt_pass", pass, 1);

    // Injected faults at index 1 (wrong y) and index 2 (wrong of)
    pulse_start();
    mm0 = mm_seen;
    drive_beat(32'h00000005, 32'h00000003, 3'd0, 32'h00000001, 1'b0, 1'b0, 1'b0);
    drive_beat(32'h12345678, 32'h87654321, 3'd2, 32'h99999998, 1'b0, 1'b0, 1'b1);
    drive_beat(32'h00000001, 32'h00000002, 3'd1, 32'h00000003, 1'b1, 1'b1, 1'b1);
    idle_inputs();
    wait_done("fault");
    check("fault_vec_count", vec_count, 3);
    check("fault_err_count", err_count, 2);
    check("fault_pass", pass, 0);
    check("fault_mismatch_pulses", mm_seen - mm0, 2);
`ifdef ALU_CHK_FIRST_ERR_EN
    check("fault_first_idx", first_err_idx, 1);
    check("fault_first_f", first_err_f, 2);
    check("fault_first_y", first_err_y, 32'h99999999);
`else
    check("fault_first_idx", first_err_idx, 0);
    check("fault_first_f", first_err_f, 0);
    check("fault_first_y", first_err_y, 0);
`endif
    repeat (3) @(negedge clk);
    check("done_hold_err", err_count, 2);
    check("done_hold_done", done, 1);

    // Unsupported function code
    pulse_start();
    mm0 = mm_seen;
    drive_beat(32'h00000000, 32'h00000000, 3'd3, 32'h00000000, 1'b0, 1'b1, 1'b1);
    idle_inputs();
    wait_done("unsup");
    check("unsup_err_count", err_count, 1);
    check("unsup_pulses", mm_seen - mm0, 1);
`ifdef ALU_CHK_FIRST_ERR_EN
    check("unsup_first_f", first_err_f, 3);
`else
    check("unsup_first_f", first_err_f, 0);
`endif

    // Saturation: 20 failing back-to-back beats, start pulsed mid-run
    pulse_start();
    mm0 = mm_seen;
    for (int i = 0; i < 20; i++) begin
      start = (i == 10);
      drive_beat(32'h0000000F, 32'h000000F0, 3'd1, 32'h00000000, 1'b0, (i == 19), 1'b1);
      start = 1'b0;
    end
    idle_inputs();
    wait_done("sat");
    check("sat_vec_count", vec_count, 4'hF);
    check("sat_err_count", err_count, 4'hF);
    check("sat_pulses", mm_seen - mm0, 20);
    check("sat_pass", pass, 0);

    // Reset mid-run after 5 accepted beats
    pulse_start();
    for (int i = 0; i < 5; i++)
      drive_beat(32'hFFFF0000, 32'h00FF00FF, 3'd0, 32'h00FF0000, 1'b0, 1'b0, 1'b0);
    idle_inputs();
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", in_ready, 0);
    pulse_start();
    drive_beat(32'h00000003, 32'h00000004, 3'd2, 32'h00000007, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    wait_done("rerun");
    check("rerun_vec_count", vec_count, 1);
    check("rerun_pass", pass, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
